// File: rtl/uart_alu_host.sv
// uart_alu_host: sends a {A, B, OP} command frame over UART TX and receives the single result byte on RX.
// All bit timing is counted in oversampling ticks; state holds between ticks.
module uart_alu_host #(
    parameter int DATA_SIZE     = 8,
    parameter int OPCODE_SIZE   = 6,
    parameter int SB_TICKS      = 16,
    parameter int TIMEOUT_TICKS = 4096,
    parameter int LEN_TIMEOUT   = 13
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_tick,
    input  logic                   i_start,
    input  logic [DATA_SIZE-1:0]   i_a,
    input  logic [DATA_SIZE-1:0]   i_b,
    input  logic [OPCODE_SIZE-1:0] i_op,
    input  logic                   i_rx,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic [DATA_SIZE-1:0]   o_result,
    output logic                   o_valid,
    output logic                   o_timeout,
    output logic                   o_frame_err
);
    localparam int SW = $clog2(SB_TICKS);
    localparam int NW = $clog2(DATA_SIZE);
    typedef enum logic [2:0] {IDLE, TX_START, TX_DATA, TX_STOP, WAIT_RESP, RX_START, RX_DATA, RX_STOP} state_t;
    state_t state, state_n;
    logic [SW-1:0] s, s_n;
    logic [NW-1:0] n, n_n;
    logic [1:0] idx, idx_n;
    logic [3*DATA_SIZE-1:0] sr, sr_n;
    logic [DATA_SIZE-1:0] b, b_n, result_n;
    logic [LEN_TIMEOUT-1:0] t, t_n;
    logic valid_n, timeout_n, frame_err_n;
    logic s_end, s_mid, n_end, s_wrap;
    assign s_end  = s == SW'(SB_TICKS - 1);
    assign s_mid  = s == SW'(SB_TICKS / 2 - 1);
    assign n_end  = n == NW'(DATA_SIZE - 1);
    assign s_wrap = s_end;
    assign o_tx   = state == TX_START ? 1'b0 : state == TX_DATA ? sr[0] : 1'b1;
    assign o_busy = state != IDLE;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            idx         <= '0;
            sr          <= '0;
            b           <= '0;
            t           <= '0;
            o_result    <= '0;
            o_valid     <= 1'b0;
            o_timeout   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            s           <= s_n;
            n           <= n_n;
            idx         <= idx_n;
            sr          <= sr_n;
            b           <= b_n;
            t           <= t_n;
            o_result    <= result_n;
            o_valid     <= valid_n;
            o_timeout   <= timeout_n;
            o_frame_err <= frame_err_n;
        end
    end
    always_comb begin
        state_n     = state;
        s_n         = s;
        n_n         = n;
        idx_n       = idx;
        sr_n        = sr;
        b_n         = b;
        t_n         = t;
        result_n    = o_result;
        valid_n     = 1'b0;
        timeout_n   = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE: if (i_start) begin
                // A sits in the low byte so plain right shifts emit A, B, OP in order
                sr_n    = {DATA_SIZE'(i_op), i_b, i_a};
                idx_n   = '0;
                s_n     = '0;
                n_n     = '0;
                state_n = TX_START;
            end
            TX_START: if (i_tick) begin
                s_n     = s_wrap ? '0 : s + 1'b1;
                state_n = s_end ? TX_DATA : TX_START;
            end
            TX_DATA: if (i_tick) begin
                s_n = s_wrap ? '0 : s + 1'b1;
                if (s_end) begin
                    sr_n    = sr >> 1;
                    n_n     = n_end ? '0 : n + 1'b1;
                    state_n = n_end ? TX_STOP : TX_DATA;
                end
            end
            TX_STOP: if (i_tick) begin
                s_n = s_wrap ? '0 : s + 1'b1;
                if (s_end) begin
                    idx_n   = idx != 2'd2 ? idx + 1'b1 : idx;
                    state_n = idx != 2'd2 ? TX_START : WAIT_RESP;
                    t_n     = '0;
                end
            end
            WAIT_RESP: if (!i_rx) begin
                // a falling edge beats a simultaneous expiry
                state_n = RX_START;
                s_n     = '0;
            end else if (i_tick) begin
                timeout_n = t == LEN_TIMEOUT'(TIMEOUT_TICKS - 1);
                state_n   = timeout_n ? IDLE : WAIT_RESP;
                t_n       = timeout_n ? t : t + 1'b1;
            end
            RX_START: if (i_tick) begin
                s_n     = s_mid ? '0 : s + 1'b1;
                n_n     = '0;
                state_n = !s_mid ? RX_START : i_rx ? WAIT_RESP : RX_DATA;
            end
            RX_DATA: if (i_tick) begin
                s_n = s_wrap ? '0 : s + 1'b1;
                if (s_end) begin
                    b_n     = {i_rx, b[DATA_SIZE-1:1]};
                    n_n     = n_end ? '0 : n + 1'b1;
                    state_n = n_end ? RX_STOP : RX_DATA;
                end
            end
            RX_STOP: if (i_tick) begin
                s_n = s_wrap ? '0 : s + 1'b1;
                if (s_end) begin
                    valid_n     = i_rx;
                    frame_err_n = !i_rx;
                    result_n    = i_rx ? b : o_result;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_alu_host.sv
// tb_uart_alu_host: drives command/response transactions with jittered ticks and checks the wire
// format, response handling, timeout and reset behaviour against an independent frame model.
module tb_uart_alu_host;
    localparam int DW = 8, OW = 6, SBT = 16, TO = 4096, NV = 12;
    typedef struct {
        logic [DW-1:0] a, b;
        logic [OW-1:0] op;
        int            mode;  // 0 good response, 1 bad stop bit, 2 no response, 3 glitch then good
        logic [DW-1:0] resp;
        int            delay;
        logic [DW-1:0] exp_result;
        logic          exp_valid, exp_ferr, exp_tmo;
    } vec_t;
    logic clk = 1'b0;
    logic i_reset, i_tick, i_start, i_rx;
    logic [DW-1:0] i_a, i_b, o_result;
    logic [OW-1:0] i_op;
    logic o_tx, o_busy, o_valid, o_timeout, o_frame_err;
    int tests = 0, fails = 0;
    int tk = 0, gap = 0;
    int n_valid, n_ferr, n_tmo, busy_bad, res_bad, tk_pulse;
    logic [DW-1:0] res_prev = '0;
    vec_t vt[NV];
    vec_t rv;
    logic [DW-1:0] last;

    uart_alu_host #(.DATA_SIZE(DW), .OPCODE_SIZE(OW), .SB_TICKS(SBT), .TIMEOUT_TICKS(TO), .LEN_TIMEOUT(13)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_tick(i_tick), .i_start(i_start),
        .i_a(i_a), .i_b(i_b), .i_op(i_op), .i_rx(i_rx),
        .o_tx(o_tx), .o_busy(o_busy), .o_result(o_result), .o_valid(o_valid),
        .o_timeout(o_timeout), .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL watchdog: run did not complete, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // one clock; ticks arrive with random spacing, and pulses/result changes are logged
    task automatic cycle();
        logic ticked;
        @(posedge clk);
        ticked = i_tick;
        #1;
        if (ticked) tk++;
        if (i_tick) begin
            i_tick = 1'b0;
            gap = $urandom_range(0, 2);
        end else if (gap == 0) i_tick = 1'b1;
        else gap--;
        if (o_valid || o_timeout || o_frame_err) begin
            tk_pulse = tk;
            if (o_busy) busy_bad++;
        end
        if (o_valid) n_valid++;
        if (o_frame_err) n_ferr++;
        if (o_timeout) n_tmo++;
        if (o_result !== res_prev && !o_valid) res_bad++;
        res_prev = o_result;
    endtask

    task automatic wait_ticks(input int n);
        int t0, c;
        t0 = tk;
        c = 0;
        while (tk - t0 < n && c < n * 6 + 10) begin
            cycle();
            c++;
        end
    endtask

    task automatic clear_mon();
        n_valid = 0; n_ferr = 0; n_tmo = 0; busy_bad = 0; res_bad = 0; tk_pulse = -1;
    endtask

    // bit k of the 30-bit command frame: each byte is start(0), 8 data bits LSB first, stop(1)
    function automatic logic exp_bit(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op, input int k);
        logic [DW-1:0] by[3];
        int p;
        by[0] = a;
        by[1] = b;
        by[2] = {2'b00, op};
        p = k % 10;
        return p == 0 ? 1'b0 : p == 9 ? 1'b1 : by[k / 10][p - 1];
    endfunction

    task automatic run_vec(input vec_t v);
        int tk_acc, k, terr, berr, tk_entry, tk_fall, c;
        logic [29:0] cap, exp;
        clear_mon();
        i_a = v.a; i_b = v.b; i_op = v.op; i_start = 1'b1;
        cycle();
        i_start = 1'b0;
        i_a = ~v.a; i_b = ~v.b; i_op = ~v.op;
        check("busy_accept", o_busy, 1);
        tk_acc = tk;
        terr = 0; berr = 0; cap = '0; c = 0;
        for (int j = 0; j < 30; j++) exp[j] = exp_bit(v.a, v.b, v.op, j);
        while (tk - tk_acc < 30 * SBT && c < 4000) begin
            k = tk - tk_acc;
            if (o_tx !== exp[k / SBT]) terr++;
            if (o_busy !== 1'b1) berr++;
            if (k % SBT == SBT / 2) cap[k / SBT] = o_tx;
            i_start = (k == 100);
            cycle();
            c++;
        end
        i_start = 1'b0;
        check("tx_timing", terr, 0);
        check("busy_tx", berr, 0);
        check("tx_frame", cap, exp);
        check("wait_entry", {o_busy, o_tx}, 2'b11);
        tk_entry = tk;
        if (v.mode == 2) begin
            c = 0;
            while (n_valid + n_ferr + n_tmo == 0 && c < (TO + 50) * 5) begin
                cycle();
                c++;
            end
            check("tmo_ticks", tk_pulse - tk_entry, TO);
        end else begin
            wait_ticks(v.delay);
            if (v.mode == 3) begin
                i_rx = 1'b0;
                wait_ticks(3);
                i_rx = 1'b1;
                wait_ticks(20);
            end
            i_rx = 1'b0;
            tk_fall = tk;
            wait_ticks(SBT);
            for (int j = 0; j < DW; j++) begin
                i_rx = v.resp[j];
                wait_ticks(SBT);
            end
            i_rx = (v.mode != 1);
            wait_ticks(SBT);
            i_rx = 1'b1;
            wait_ticks(24);
            check("rx_latency", (tk_pulse - tk_fall == 152) || (tk_pulse - tk_fall == 153), 1);
        end
        check("valid_cnt", n_valid, v.exp_valid);
        check("ferr_cnt", n_ferr, v.exp_ferr);
        check("tmo_cnt", n_tmo, v.exp_tmo);
        check("result", o_result, v.exp_result);
        check("busy_at_pulse", busy_bad, 0);
        check("result_hold", res_bad, 0);
        check("busy_end", o_busy, 0);
    endtask

    initial begin
        int m;
        i_reset = 1'b1; i_tick = 1'b0; i_start = 1'b0; i_rx = 1'b1;
        i_a = '0; i_b = '0; i_op = '0;
        vt[0] = '{8'h05, 8'h03, 6'h20, 0, 8'h08, 50, 8'h08, 1'b1, 1'b0, 1'b0};
        vt[1] = '{8'h11, 8'h22, 6'h01, 2, 8'h00, 0, 8'h08, 1'b0, 1'b0, 1'b1};
        vt[2] = '{8'h7F, 8'h80, 6'h3F, 1, 8'hA5, 30, 8'h08, 1'b0, 1'b1, 1'b0};
        vt[3] = '{8'hC3, 8'h5A, 6'h15, 3, 8'h3C, 10, 8'h3C, 1'b1, 1'b0, 1'b0};
        last = 8'h3C;
        for (int r = 4; r < NV; r++) begin
            m = $urandom_range(0, 3);
            if (m == 2) m = 0;
            vt[r].a = 8'($urandom);
            vt[r].b = 8'($urandom);
            vt[r].op = 6'($urandom);
            vt[r].mode = m;
            vt[r].resp = 8'($urandom);
            vt[r].delay = $urandom_range(1, 200);
            if (m != 1) last = vt[r].resp;
            vt[r].exp_result = last;
            vt[r].exp_valid = (m != 1);
            vt[r].exp_ferr = (m == 1);
            vt[r].exp_tmo = 1'b0;
        end
        repeat (3) cycle();
        i_reset = 1'b0;
        cycle();
        check("rst_tx", o_tx, 1);
        check("rst_busy", o_busy, 0);
        check("rst_result", o_result, 0);
        check("rst_valid", o_valid, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_frame_err", o_frame_err, 0);
        for (int r = 0; r < NV; r++) run_vec(vt[r]);
        // abort a frame while a zero data bit of A is on the wire
        i_a = 8'h00; i_b = 8'h00; i_op = 6'h00; i_start = 1'b1;
        cycle();
        i_start = 1'b0;
        wait_ticks(40);
        check("tx_pre_reset", o_tx, 0);
        i_reset = 1'b1;
        cycle();
        check("reset_tx", o_tx, 1);
        check("reset_busy", o_busy, 0);
        check("reset_result", o_result, 0);
        i_reset = 1'b0;
        cycle();
        rv = '{8'h9A, 8'h21, 6'h2A, 0, 8'h5E, 5, 8'h5E, 1'b1, 1'b0, 1'b0};
        run_vec(rv);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_alu_host.md
Name: uart_alu_host

Overview:
Host-side initiator for the ALU-over-UART link. On a start request it serializes one command frame (operand A, operand B, opcode) onto a UART TX line. It then receives the single result byte returned by the remote ALU node on a UART RX line. It is used as the bench/peer driver and in loopback builds. It shares the oversampling tick (16 ticks per bit) produced by the tick generator.

Parameters:
DATA_SIZE, 8, width of operands A/B and result; must equal the UART byte width.
OPCODE_SIZE, 6, opcode width; zero-extended to DATA_SIZE on the wire.
SB_TICKS, 16, ticks per bit (start, data and stop bits).
TIMEOUT_TICKS, 4096, ticks allowed in WAIT_RESP before a start bit is detected.
LEN_TIMEOUT, 13, width of the timeout counter.

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_tick  in  1  oversampling tick, one-cycle pulse, 16 per bit period
i_start  in  1  command request; sampled only in IDLE
i_a  in  DATA_SIZE  operand A; latched on accepted start
i_b  in  DATA_SIZE  operand B; latched on accepted start
i_op  in  OPCODE_SIZE  opcode; latched on accepted start
i_rx  in  1  serial result line from the ALU node; idle high; treated as already synchronized
o_tx  out  1  serial command line to the ALU node; idle high
o_busy  out  1  high from the cycle after start is accepted until return to IDLE
o_result  out  DATA_SIZE  last received result; holds its value until the next valid
o_valid  out  1  one-cycle pulse when o_result updates
o_timeout  out  1  one-cycle pulse on response timeout
o_frame_err  out  1  one-cycle pulse when the response stop bit is sampled low

Behaviour:
- Reset: state IDLE; o_tx=1; o_busy=0; o_result=0; o_valid=0; o_timeout=0; o_frame_err=0; all counters 0. Reset mid-frame aborts immediately; o_tx returns high the next cycle.
- FSM states: IDLE, TX_START, TX_DATA, TX_STOP, WAIT_RESP, RX_START, RX_DATA, RX_STOP.
- IDLE:
  - When i_start=1, latch {A, B, zero-extended op} into a 3-entry byte shift register.
  - Clear the byte index to 0 and go to TX_START. o_busy=1 from the next cycle.
  - i_start in any other state is ignored.
- TX path. Tick counter s counts i_tick only; bit counter n counts data bits.
  - TX_START: o_tx=0 for SB_TICKS ticks.
  - TX_DATA: send 8 bits LSB first, SB_TICKS ticks each.
  - TX_STOP: o_tx=1 for SB_TICKS ticks.
  - At the end of stop: if byte index<2, increment it and go to TX_START (back-to-back, no idle gap). Otherwise go to WAIT_RESP.
  - Byte order on the wire: A, B, OP.
- WAIT_RESP:
  - The timeout counter increments on each i_tick.
  - i_rx=0 in any cycle → RX_START, counter cleared.
  - If the counter reaches TIMEOUT_TICKS-1 on a tick with i_rx still high: pulse o_timeout, go to IDLE; o_result unchanged.
  - If i_rx falls on the same tick as expiry, the start bit wins.
- RX_START:
  - After 7 ticks (mid start bit), re-sample i_rx.
  - If 0 → RX_DATA with s=0. If 1 (glitch) → return to WAIT_RESP; the timeout counter is not reset.
- RX_DATA: on every 16th tick (s==15), shift i_rx in LSB first. After 8 bits → RX_STOP.
- RX_STOP:
  - On the 16th tick, sample i_rx.
  - If 1: o_result ← assembled byte, o_valid pulse, go to IDLE.
  - If 0: o_frame_err pulse, o_result unchanged, go to IDLE.
- o_busy deasserts in the same cycle the valid/timeout/frame_err pulse is issued. A new i_start is accepted the following cycle.
- Counters advance only on i_tick. Between ticks, state and outputs hold.
- Latency: TX frame = 3×10×SB_TICKS = 480 ticks from acceptance to WAIT_RESP.

Test Plan:
- Reset, then i_start with A=8'h05, B=8'h03, op=6'h20 → o_tx carries bytes 05, 03, 20, each with start bit, LSB first and stop bit, 160 ticks per byte with no gaps; o_busy high throughout.
- After the frame, the bench drives response 8'h08 on i_rx 50 ticks later → o_valid one-cycle pulse, o_result=8'h08, o_busy=0 in the same cycle.
- No response → o_timeout pulse exactly 4096 ticks after WAIT_RESP entry; o_result keeps its previous value 8'h08.
- Response 8'hA5 with stop bit driven low → o_frame_err pulse, no o_valid, o_result unchanged.
- In WAIT_RESP, a 3-tick low glitch on i_rx, then a valid 8'h3C → glitch rejected, o_result=8'h3C; i_start asserted while busy is ignored; i_reset mid-TX_DATA → o_tx=1 and o_busy=0 the next cycle.
